// File: rtl/altera_tse_gxb_rxsync_lanes.sv
// altera_tse_gxb_rxsync_lanes
// Per-lane receive-sync qualifier between the transceiver 8b/10b decoder and
// the 1000BASE-X PCS receive state machine. Each lane pipelines the decoder
// status, qualifies word-aligner sync with acquire/degrade hysteresis, masks
// data to idle-error values while unqualified, and produces a comma-qualified
// carrier-detect flag plus a one-cycle sync-lost pulse. Lanes share no state.

module altera_tse_gxb_rxsync_lanes #(
    parameter int NUM_LANES   = 1,
    parameter int PIPE_DEPTH  = 1,
    parameter int SYNC_ON_CNT = 4,
    parameter int ERR_LIMIT   = 3,
    parameter int CLEAN_CNT   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [8*NUM_LANES-1:0]   alt_dataout,
    input  logic [NUM_LANES-1:0]     alt_sync,
    input  logic [NUM_LANES-1:0]     alt_ctrldetect,
    input  logic [NUM_LANES-1:0]     alt_errdetect,
    input  logic [NUM_LANES-1:0]     alt_disperr,
    input  logic [NUM_LANES-1:0]     alt_patterndetect,
    input  logic [NUM_LANES-1:0]     alt_rmfifodatadeleted,
    input  logic [NUM_LANES-1:0]     alt_rmfifodatainserted,
    output logic [8*NUM_LANES-1:0]   altpcs_dataout,
    output logic [NUM_LANES-1:0]     altpcs_ctrldetect,
    output logic [NUM_LANES-1:0]     altpcs_errdetect,
    output logic [NUM_LANES-1:0]     altpcs_disperr,
    output logic [NUM_LANES-1:0]     altpcs_rmfifodatadeleted,
    output logic [NUM_LANES-1:0]     altpcs_rmfifodatainserted,
    output logic [NUM_LANES-1:0]     altpcs_sync,
    output logic [NUM_LANES-1:0]     altpcs_carrierdetect,
    output logic [NUM_LANES-1:0]     altpcs_sync_lost
);

    // Packed per-lane status word carried through the input pipeline.
    localparam int LW      = 15;
    localparam int B_SYNC  = 8;
    localparam int B_CTRL  = 9;
    localparam int B_ERR   = 10;
    localparam int B_DISP  = 11;
    localparam int B_PAT   = 12;
    localparam int B_RMD   = 13;
    localparam int B_RMI   = 14;

    // Terminal counter values, pre-computed at the 8-bit counter width.
    localparam logic [7:0] ON_LAST    = 8'(SYNC_ON_CNT - 1);
    localparam logic [7:0] ERR_LAST   = 8'(ERR_LIMIT - 1);
    localparam logic [7:0] CLEAN_LAST = 8'(CLEAN_CNT - 1);

    typedef enum logic [1:0] {
        ST_LOS     = 2'd0,
        ST_ACQ     = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_DEGRADE = 2'd3
    } state_t;

    // K28.5 comma: data BC with the control flag and comma-detect both set.
    function automatic logic is_k285(input logic [7:0] data, input logic ctrl,
                                     input logic pat);
        return (data == 8'hBC) && ctrl && pat;
    endfunction

    // A cycle is errored when either a code-group or disparity error is seen.
    function automatic logic is_err_cycle(input logic errdet, input logic disperr);
        return errdet | disperr;
    endfunction

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane

        logic [LW-1:0] lane_in_s;
        logic [LW-1:0] pipe_r [PIPE_DEPTH];
        logic [LW-1:0] stage_s;

        logic          stage_sync_s;
        logic          stage_err_s;
        logic          stage_k_s;
        logic          qualified_s;
        logic          to_los_s;

        state_t        state_r;
        logic [7:0]    on_cnt_r;
        logic [7:0]    err_cnt_r;
        logic [7:0]    clean_cnt_r;
        logic          sync_lost_r;
        logic          carrier_r;

        logic [7:0]    data_r;
        logic          ctrl_r;
        logic          errdet_r;
        logic          disperr_r;
        logic          rmd_r;
        logic          rmi_r;

        assign lane_in_s = {alt_rmfifodatainserted[i], alt_rmfifodatadeleted[i],
                            alt_patterndetect[i], alt_disperr[i], alt_errdetect[i],
                            alt_ctrldetect[i], alt_sync[i], alt_dataout[8*i +: 8]};

        // Input pipeline: stage 0 captures the decoder, later stages shift.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s < PIPE_DEPTH; s++) begin
                    pipe_r[s] <= {LW{1'b0}};
                end
            end else begin
                pipe_r[0] <= lane_in_s;
                for (int s = 1; s < PIPE_DEPTH; s++) begin
                    pipe_r[s] <= pipe_r[s-1];
                end
            end
        end

        assign stage_s      = pipe_r[PIPE_DEPTH-1];
        assign stage_sync_s = stage_s[B_SYNC];
        assign stage_err_s  = is_err_cycle(stage_s[B_ERR], stage_s[B_DISP]);
        assign stage_k_s    = is_k285(stage_s[7:0], stage_s[B_CTRL], stage_s[B_PAT]);
        assign qualified_s  = (state_r == ST_LOCKED) || (state_r == ST_DEGRADE);

        // Lock is dropped on this edge: sync loss, or the error budget runs out.
        always_comb begin
            to_los_s = 1'b0;
            if (!stage_sync_s) begin
                to_los_s = 1'b1;
            end else if (state_r == ST_LOCKED) begin
                to_los_s = stage_err_s && (ERR_LIMIT == 1);
            end else if (state_r == ST_DEGRADE) begin
                to_los_s = stage_err_s && (err_cnt_r == ERR_LAST);
            end else begin
                to_los_s = 1'b0;
            end
        end

        // Sync-qualification FSM with its registered outputs (mask, carrier, pulse).
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_r     <= ST_LOS;
                on_cnt_r    <= 8'h00;
                err_cnt_r   <= 8'h00;
                clean_cnt_r <= 8'h00;
                sync_lost_r <= 1'b0;
                carrier_r   <= 1'b0;
                data_r      <= 8'h00;
                ctrl_r      <= 1'b0;
                errdet_r    <= 1'b1;
                disperr_r   <= 1'b1;
                rmd_r       <= 1'b0;
                rmi_r       <= 1'b0;
            end else begin
                // Pulse only when a qualified lane falls back to LOS.
                sync_lost_r <= qualified_s && to_los_s;

                // Entering LOS beats a coincident comma.
                if (to_los_s) begin
                    carrier_r <= 1'b0;
                end else if (qualified_s && stage_k_s) begin
                    carrier_r <= 1'b1;
                end else begin
                    carrier_r <= carrier_r;
                end

                // Pass stage values only while qualified and still in sync.
                if (qualified_s && stage_sync_s) begin
                    data_r    <= stage_s[7:0];
                    ctrl_r    <= stage_s[B_CTRL];
                    errdet_r  <= stage_s[B_ERR];
                    disperr_r <= stage_s[B_DISP];
                    rmd_r     <= stage_s[B_RMD];
                    rmi_r     <= stage_s[B_RMI];
                end else begin
                    data_r    <= 8'h00;
                    ctrl_r    <= 1'b0;
                    errdet_r  <= 1'b1;
                    disperr_r <= 1'b1;
                    rmd_r     <= 1'b0;
                    rmi_r     <= 1'b0;
                end

                if (!stage_sync_s) begin
                    state_r     <= ST_LOS;
                    on_cnt_r    <= 8'h00;
                    err_cnt_r   <= 8'h00;
                    clean_cnt_r <= 8'h00;
                end else begin
                    case (state_r)
                        ST_LOS: begin
                            if (SYNC_ON_CNT == 1) begin
                                state_r  <= ST_LOCKED;
                                on_cnt_r <= 8'h00;
                            end else begin
                                state_r  <= ST_ACQ;
                                on_cnt_r <= 8'h01;
                            end
                        end
                        ST_ACQ: begin
                            // Errors do not disturb acquisition.
                            if (on_cnt_r == ON_LAST) begin
                                state_r  <= ST_LOCKED;
                                on_cnt_r <= 8'h00;
                            end else begin
                                on_cnt_r <= on_cnt_r + 8'h01;
                            end
                        end
                        ST_LOCKED: begin
                            if (stage_err_s) begin
                                if (ERR_LIMIT == 1) begin
                                    state_r     <= ST_LOS;
                                    err_cnt_r   <= 8'h00;
                                    clean_cnt_r <= 8'h00;
                                end else begin
                                    state_r     <= ST_DEGRADE;
                                    err_cnt_r   <= 8'h01;
                                    clean_cnt_r <= 8'h00;
                                end
                            end else begin
                                state_r <= ST_LOCKED;
                            end
                        end
                        ST_DEGRADE: begin
                            if (stage_err_s) begin
                                if (err_cnt_r == ERR_LAST) begin
                                    state_r     <= ST_LOS;
                                    err_cnt_r   <= 8'h00;
                                    clean_cnt_r <= 8'h00;
                                end else begin
                                    err_cnt_r   <= err_cnt_r + 8'h01;
                                    clean_cnt_r <= 8'h00;
                                end
                            end else if (clean_cnt_r == CLEAN_LAST) begin
                                // Error count is only forgotten on a full recovery.
                                state_r     <= ST_LOCKED;
                                err_cnt_r   <= 8'h00;
                                clean_cnt_r <= 8'h00;
                            end else begin
                                clean_cnt_r <= clean_cnt_r + 8'h01;
                            end
                        end
                        default: begin
                            state_r     <= ST_LOS;
                            on_cnt_r    <= 8'h00;
                            err_cnt_r   <= 8'h00;
                            clean_cnt_r <= 8'h00;
                        end
                    endcase
                end
            end
        end

        assign altpcs_dataout[8*i +: 8]       = data_r;
        assign altpcs_ctrldetect[i]           = ctrl_r;
        assign altpcs_errdetect[i]            = errdet_r;
        assign altpcs_disperr[i]              = disperr_r;
        assign altpcs_rmfifodatadeleted[i]    = rmd_r;
        assign altpcs_rmfifodatainserted[i]   = rmi_r;
        assign altpcs_sync[i]                 = qualified_s;
        assign altpcs_carrierdetect[i]        = carrier_r;
        assign altpcs_sync_lost[i]            = sync_lost_r;
    end

endmodule

// File: tb/tb_altera_tse_gxb_rxsync_lanes.sv
// Directed bench for altera_tse_gxb_rxsync_lanes with two lanes, two pipeline
// stages, lock after 4 synced cycles, error limit 3 and clean count 2.
// Inputs change 1 ns after a rising edge ("cycle n" follows edge n); outputs
// are sampled 1 ns after each edge.

module tb_altera_tse_gxb_rxsync_lanes;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] din;
    logic [1:0]  sync, ctrl, err, disp, pat, rmd, rmi;

    logic [15:0] q_data;
    logic [1:0]  q_ctrl, q_err, q_disp, q_rmd, q_rmi, q_sync, q_car, q_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    altera_tse_gxb_rxsync_lanes #(
        .NUM_LANES(2), .PIPE_DEPTH(2), .SYNC_ON_CNT(4), .ERR_LIMIT(3), .CLEAN_CNT(2)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .alt_dataout               (din),
        .alt_sync                  (sync),
        .alt_ctrldetect            (ctrl),
        .alt_errdetect             (err),
        .alt_disperr               (disp),
        .alt_patterndetect         (pat),
        .alt_rmfifodatadeleted     (rmd),
        .alt_rmfifodatainserted    (rmi),
        .altpcs_dataout            (q_data),
        .altpcs_ctrldetect         (q_ctrl),
        .altpcs_errdetect          (q_err),
        .altpcs_disperr            (q_disp),
        .altpcs_rmfifodatadeleted  (q_rmd),
        .altpcs_rmfifodatainserted (q_rmi),
        .altpcs_sync               (q_sync),
        .altpcs_carrierdetect      (q_car),
        .altpcs_sync_lost          (q_lost)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        din  = 16'($urandom); sync = 2'($urandom); ctrl = 2'($urandom);
        err  = 2'($urandom);  disp = 2'($urandom); pat  = 2'($urandom);
        rmd  = 2'($urandom);  rmi  = 2'($urandom);
        tick(3);
        checks++; if (q_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", q_data); end
        checks++; if (q_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", q_ctrl); end
        checks++; if (q_err !== 2'b11) begin errors++; $display("FAIL reset_err: got %b want 11", q_err); end
        checks++; if (q_disp !== 2'b11) begin errors++; $display("FAIL reset_disp: got %b want 11", q_disp); end
        checks++; if ({q_rmd, q_rmi} !== 4'b0000) begin errors++; $display("FAIL reset_rm: got %b want 0000", {q_rmd, q_rmi}); end
        checks++; if ({q_sync, q_car, q_lost} !== 6'b000000) begin errors++; $display("FAIL reset_status: got %b want 000000", {q_sync, q_car, q_lost}); end
        din = 16'h0000; sync = 2'b00; ctrl = 2'b00; err = 2'b00; disp = 2'b00;
        pat = 2'b00; rmd = 2'b00; rmi = 2'b00;
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_acquire;
        sync = 2'b01;
        din  = 16'h0055;
        tick(5);
        checks++; if (q_sync !== 2'b00) begin errors++; $display("FAIL acq_early: got %b want 00", q_sync); end
        tick(1);
        checks++; if (q_sync !== 2'b01) begin errors++; $display("FAIL acq_lock: got %b want 01", q_sync); end
        tick(1);
        checks++; if (q_data !== 16'h0055) begin errors++; $display("FAIL acq_data: got %h want 0055", q_data); end
        checks++; if (q_err !== 2'b10) begin errors++; $display("FAIL acq_err: got %b want 10", q_err); end
        checks++; if (q_disp !== 2'b10) begin errors++; $display("FAIL acq_disp: got %b want 10", q_disp); end
        // Data latency: a new byte shows up three edges after it is driven.
        din = 16'h00A5; rmd = 2'b01; rmi = 2'b01;
        tick(2);
        checks++; if (q_data !== 16'h0055) begin errors++; $display("FAIL lat_early: got %h want 0055", q_data); end
        tick(1);
        checks++; if (q_data !== 16'h00A5) begin errors++; $display("FAIL lat_data: got %h want 00a5", q_data); end
        checks++; if ({q_rmd, q_rmi} !== 4'b0101) begin errors++; $display("FAIL lat_rm: got %b want 0101", {q_rmd, q_rmi}); end
        rmd = 2'b00; rmi = 2'b00;
        tick(3);
    endtask

    task automatic test_degrade_recover;
        err = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 1) err = 2'b00;
            checks++; if (q_sync[0] !== 1'b1) begin errors++; $display("FAIL deg_rec_sync k=%0d: got %b want 1", k, q_sync[0]); end
            checks++; if (q_lost[0] !== 1'b0) begin errors++; $display("FAIL deg_rec_lost k=%0d: got %b want 0", k, q_lost[0]); end
            if (k == 3) begin
                checks++; if (q_err[0] !== 1'b1) begin errors++; $display("FAIL deg_rec_errpass: got %b want 1", q_err[0]); end
            end
        end
    endtask

    task automatic test_degrade_loss;
        logic [4:0] epat;
        epat = 5'b10101;
        for (int k = 0; k < 10; k++) begin
            err[0] = (k < 5) ? epat[k] : 1'b0;
            tick(1);
            checks++; if (q_sync[0] !== ((k + 1) <= 6)) begin errors++; $display("FAIL deg_loss_sync edge=%0d: got %b want %b", k + 1, q_sync[0], ((k + 1) <= 6)); end
            checks++; if (q_lost[0] !== ((k + 1) == 7)) begin errors++; $display("FAIL deg_loss_lost edge=%0d: got %b want %b", k + 1, q_lost[0], ((k + 1) == 7)); end
        end
        tick(4);
        checks++; if (q_sync[0] !== 1'b1) begin errors++; $display("FAIL deg_loss_relock: got %b want 1", q_sync[0]); end
    endtask

    task automatic test_carrier;
        din[15:8] = 8'hBC; ctrl[1] = 1'b1; pat[1] = 1'b1; sync[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            checks++; if (q_car[1] !== (k >= 7)) begin errors++; $display("FAIL car_acq k=%0d: got %b want %b", k, q_car[1], (k >= 7)); end
        end
        checks++; if (q_data[15:8] !== 8'hBC || q_ctrl[1] !== 1'b1) begin errors++; $display("FAIL car_data: got %h/%b want bc/1", q_data[15:8], q_ctrl[1]); end
        sync[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            checks++; if (q_car[1] !== (k <= 2)) begin errors++; $display("FAIL car_drop k=%0d: got %b want %b", k, q_car[1], (k <= 2)); end
            checks++; if (q_lost[1] !== (k == 3)) begin errors++; $display("FAIL car_lost k=%0d: got %b want %b", k, q_lost[1], (k == 3)); end
            checks++; if (q_sync !== {(k <= 2), 1'b1}) begin errors++; $display("FAIL car_sync k=%0d: got %b want %b1", k, q_sync, (k <= 2)); end
            if (k == 3) begin
                checks++; if (q_data[15:8] !== 8'h00 || q_err[1] !== 1'b1) begin errors++; $display("FAIL car_mask: got %h/%b want 00/1", q_data[15:8], q_err[1]); end
            end
        end
    endtask

    task automatic test_acq_dropout;
        for (int k = 0; k <= 10; k++) begin
            sync[1] = (k == 3) ? 1'b0 : 1'b1;
            tick(1);
            checks++; if (q_sync[1] !== ((k + 1) >= 10)) begin errors++; $display("FAIL dropout_sync edge=%0d: got %b want %b", k + 1, q_sync[1], ((k + 1) >= 10)); end
            checks++; if (q_lost[1] !== 1'b0) begin errors++; $display("FAIL dropout_lost edge=%0d: got %b want 0", k + 1, q_lost[1]); end
        end
        checks++; if (q_car[1] !== 1'b1) begin errors++; $display("FAIL dropout_car: got %b want 1", q_car[1]); end
    endtask

    task automatic test_reset_mid_lock;
        din[7:0] = 8'hBC; ctrl[0] = 1'b1; pat[0] = 1'b1;
        tick(4);
        checks++; if ({q_sync, q_car} !== 4'b1111) begin errors++; $display("FAIL midrst_pre: got %b want 1111", {q_sync, q_car}); end
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        checks++; if (q_data !== 16'h0000) begin errors++; $display("FAIL midrst_data: got %h want 0000", q_data); end
        checks++; if ({q_ctrl, q_err, q_disp, q_rmd, q_rmi} !== 10'b00_11_11_00_00) begin errors++; $display("FAIL midrst_flags: got %b want 0011110000", {q_ctrl, q_err, q_disp, q_rmd, q_rmi}); end
        checks++; if ({q_sync, q_car, q_lost} !== 6'b000000) begin errors++; $display("FAIL midrst_status: got %b want 000000", {q_sync, q_car, q_lost}); end
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            checks++; if ({q_sync, q_lost} !== 4'b0000) begin errors++; $display("FAIL midrst_after k=%0d: got %b want 0000", k, {q_sync, q_lost}); end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_degrade_recover();
        test_degrade_loss();
        test_carrier();
        test_acq_dropout();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
